// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel magnitude frame controller.
//   state_t   : frame sequencer states
//   GRAD_W    : signed gradient width
//   PIX_W     : magnitude pixel width
//   clog2     : width helper, never returns less than 1 so ports stay non-empty
//   grad_abs  : absolute value of a signed gradient, one bit wider than the input
package sobel_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int GRAD_W = 10;
    localparam int PIX_W  = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // The extra bit keeps |-2^(GRAD_W-1)| representable.
    function automatic logic [GRAD_W:0] grad_abs(input logic signed [GRAD_W-1:0] g);
        logic [GRAD_W:0] ext;
        ext = {g[GRAD_W-1], g};
        return g[GRAD_W-1] ? (~ext + 1'b1) : ext;
    endfunction

endpackage

// File: rtl/mag_frame_ctrl_if.sv
// Stream bundle for mag_frame_ctrl.
//   in_valid/in_ready/in_gx/in_gy       : gradient pair input handshake
//   out_valid/out_ready/out_pixel/...   : tagged magnitude pixel output handshake
//   master : producer of gradients / consumer of pixels (the environment)
//   slave  : the frame controller
interface mag_frame_ctrl_if
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 4,
    parameter int IMG_HEIGHT = 2
) ();

    logic                             in_valid;
    logic                             in_ready;
    logic signed [GRAD_W-1:0]         in_gx;
    logic signed [GRAD_W-1:0]         in_gy;
    logic                             out_valid;
    logic                             out_ready;
    logic [PIX_W-1:0]                 out_pixel;
    logic [clog2(IMG_WIDTH)-1:0]      out_col;
    logic [clog2(IMG_HEIGHT)-1:0]     out_row;

    modport master (
        output in_valid, in_gx, in_gy, out_ready,
        input  in_ready, out_valid, out_pixel, out_col, out_row
    );

    modport slave (
        input  in_valid, in_gx, in_gy, out_ready,
        output in_ready, out_valid, out_pixel, out_col, out_row
    );

endinterface

// File: rtl/mag_result_fifo.sv
// Synchronous result FIFO for magnitude pixels; any depth (pointers wrap explicitly).
//   push/din  : write when push is high (caller guarantees space)
//   pop/dout  : dout shows the head; pop advances it (caller guarantees non-empty)
//   count     : occupancy, simultaneous push and pop leaves it unchanged
//   empty     : count == 0
module mag_result_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int PIX_W      = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      push,
    input  logic                                      pop,
    input  logic [PIX_W-1:0]                          din,
    output logic [PIX_W-1:0]                          dout,
    output logic [sobel_pkg::clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                                      empty
);

    localparam int AW = sobel_pkg::clog2(FIFO_DEPTH);

    logic [PIX_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/sobel_mag.sv
// Existing magnitude block: two register stages from gx/gy to mag.
//   clk, n_rst : clock, synchronous active-low reset
//   gx, gy     : signed gradients
//   mag        : quantised edge magnitude, |gx|+|gy| scaled by 5/64, saturating
module sobel_mag
    import sobel_pkg::*;
(
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic signed [GRAD_W-1:0] gx,
    input  logic signed [GRAD_W-1:0] gy,
    input  logic                     unused_tie = 1'b0,
    output logic [PIX_W-1:0]         mag
);

    localparam int SHIFT = 6;

    logic [GRAD_W:0]   sum_q;
    logic [GRAD_W+2:0] scaled;

    // sum*5 = sum + 4*sum; fits GRAD_W+3 bits for the full input range.
    always_comb begin
        scaled = {2'b00, sum_q} + {sum_q, 2'b00};
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sum_q <= '0;
            mag   <= '0;
        end else begin
            sum_q <= grad_abs(gx) + grad_abs(gy);
            mag   <= (|scaled[GRAD_W+2:SHIFT+PIX_W]) ? '1 : scaled[SHIFT+PIX_W-1:SHIFT];
        end
    end

endmodule

// File: rtl/mag_frame_ctrl.sv
// Frame sequencer around the Sobel magnitude pipeline.
//   clk, rst    : clock, synchronous active-high reset
//   start       : begins a frame when idle, ignored otherwise
//   bus (slave) : gradient input stream and tagged pixel output stream
//   busy        : high whenever a frame is in progress
//   frame_done  : one-cycle pulse once every pixel of the frame has been taken
// Input credit counts pixels still in the pipeline plus those in the FIFO,
// so the FIFO can never overflow regardless of downstream backpressure.
module mag_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH   = 4,
    parameter int IMG_HEIGHT  = 2,
    parameter int MAG_LATENCY = 3,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    mag_frame_ctrl_if.slave  bus,
    output logic             busy,
    output logic             frame_done
);

    localparam int COL_W = clog2(IMG_WIDTH);
    localparam int ROW_W = clog2(IMG_HEIGHT);
    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int ACC_W = clog2(TOTAL + 1);
    localparam int CNT_W = clog2(FIFO_DEPTH + 1);
    localparam int INF_W = clog2(MAG_LATENCY + 1);

    // Input register plus the two stages inside sobel_mag.
    if (MAG_LATENCY != 3) begin : g_bad_latency
        $error("MAG_LATENCY must match the magnitude pipeline (3)");
    end
    if (FIFO_DEPTH < MAG_LATENCY + 1) begin : g_bad_depth
        $error("FIFO_DEPTH must be at least MAG_LATENCY+1");
    end

    state_t                   state, state_nxt;
    logic                     in_ready, accept, credit_ok;
    logic                     push, pop, fifo_empty;
    logic [CNT_W-1:0]         fifo_count;
    logic [MAG_LATENCY-1:0]   vsr;
    logic [INF_W-1:0]         inflight;
    logic [ACC_W-1:0]         acc_cnt;
    logic signed [GRAD_W-1:0] gx_q, gy_q;
    logic [PIX_W-1:0]         mag, fifo_dout;
    logic [COL_W-1:0]         col_q;
    logic [ROW_W-1:0]         row_q;
    logic                     n_rst;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < MAG_LATENCY; i++) begin
            inflight = inflight + INF_W'(vsr[i]);
        end
    end

    always_comb begin
        credit_ok = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                in_ready = credit_ok;
                accept   = bus.in_valid && credit_ok;
                if (accept && acc_cnt == ACC_W'(TOTAL - 1)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (inflight == '0 && fifo_empty) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_DONE);
    assign push       = vsr[MAG_LATENCY-1];
    assign pop        = !fifo_empty && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            acc_cnt <= '0;
            vsr     <= '0;
            gx_q    <= '0;
            gy_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state <= state_nxt;
            vsr   <= (vsr << 1) | MAG_LATENCY'(accept);
            if (accept) begin
                gx_q <= bus.in_gx;
                gy_q <= bus.in_gy;
            end
            if (state == S_IDLE && start) begin
                acc_cnt <= '0;
                col_q   <= '0;
                row_q   <= '0;
            end else begin
                if (accept) acc_cnt <= acc_cnt + 1'b1;
                if (pop) begin
                    if (col_q == COL_W'(IMG_WIDTH - 1)) begin
                        col_q <= '0;
                        row_q <= (row_q == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
            end
        end
    end

    assign n_rst = ~rst;

    sobel_mag u_mag (
        .clk        (clk),
        .n_rst      (n_rst),
        .gx         (gx_q),
        .gy         (gy_q),
        .unused_tie (1'b0),
        .mag        (mag)
    );

    mag_result_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .PIX_W      (PIX_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (mag),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_pixel = fifo_empty ? '0 : fifo_dout;
    assign bus.out_col   = col_q;
    assign bus.out_row   = row_q;

endmodule

// File: tb/tb_mag_frame_ctrl.sv
// Bench for mag_frame_ctrl: directed stimulus pushes expected tagged pixels
// into a queue, an independent negedge monitor pops and compares them.
module tb_mag_frame_ctrl;
    import sobel_pkg::*;

    localparam int W = 4;
    localparam int H = 2;

    logic tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    logic rst, start, busy, frame_done;

    mag_frame_ctrl_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();

    mag_frame_ctrl #(
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H),
        .MAG_LATENCY (3),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk        (tb_clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done)
    );

    typedef struct {
        int pix;
        int row;
        int col;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   first_valid_cyc = -1;
    int   first_acc_cyc   = -1;
    int   last_pop_cyc    = -1;
    int   m_row = 0;
    int   m_col = 0;
    bit   tog   = 1'b0;

    int gx_bp  [8] = '{0, 32, 64, 96, 128, 160, 192, 224};
    int exp_bp [8] = '{0, 2, 5, 7, 10, 12, 15, 15};
    int gv_ord [4] = '{0, 150, -150, 64};
    int exp_ord[4] = '{0, 15, 15, 10};

    always @(posedge tb_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input int want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    // Monitor: every taken output pixel must match the head of the scoreboard.
    always @(negedge tb_clk) begin : mon
        exp_t e;
        int   d;
        if (bus.out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            last_pop_cyc = cyc;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pixel: got %0d at (%0d,%0d) want none",
                         bus.out_pixel, bus.out_row, bus.out_col);
            end else begin
                e = sb.pop_front();
                d = int'(bus.out_pixel) - e.pix;
                total++;
                if ($isunknown(bus.out_pixel) || d > 1 || d < -1) begin
                    bad++;
                    $display("FAIL out_pixel: got %0d want %0d+-1", bus.out_pixel, e.pix);
                end
                chk("out_row", bus.out_row, e.row);
                chk("out_col", bus.out_col, e.col);
            end
        end
    end

    task automatic step();
        @(posedge tb_clk);
        #1;
        if (tog) bus.out_ready = ~bus.out_ready;
    endtask

    task automatic push_exp(input int pix);
        sb.push_back('{pix, m_row, m_col});
        if (m_col == W - 1) begin
            m_col = 0;
            m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end else begin
            m_col = m_col + 1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input int gx, input int gy, input int pix);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_gx    = gx[GRAD_W-1:0];
        bus.in_gy    = gy[GRAD_W-1:0];
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge tb_clk);
            if (bus.in_ready === 1'b1) ok = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        if (ok) begin
            push_exp(pix);
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
        end else begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no in_ready want accept within 100 cycles");
        end
    endtask

    task automatic wait_done(input string name);
        int pulses;
        int done_c;
        pulses = 0;
        done_c = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge tb_clk);
            if (frame_done === 1'b1) begin
                pulses++;
                if (done_c < 0) done_c = cyc;
            end else if (done_c >= 0 && cyc == done_c + 1) begin
                chk({name, "_busy_after_done"}, busy, 0);
            end
            step();
        end
        chk({name, "_done_pulses"}, pulses, 1);
        chk({name, "_done_after_last_pop"}, done_c > last_pop_cyc, 1);
        chk({name, "_pixels_outstanding"}, sb.size(), 0);
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_in_ready"},   bus.in_ready,  0);
        chk({p, "_out_valid"},  bus.out_valid, 0);
        chk({p, "_busy"},       busy,          0);
        chk({p, "_frame_done"}, frame_done,    0);
        chk({p, "_out_pixel"},  bus.out_pixel, 0);
        chk({p, "_out_row"},    bus.out_row,   0);
        chk({p, "_out_col"},    bus.out_col,   0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion want finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst           = 1'b1;
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_gx     = '0;
        bus.in_gy     = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        @(negedge tb_clk);
        chk_reset("reset");
        step();
        rst = 1'b0;
        step();

        // Full-rate frame, 8 back-to-back pairs, no backpressure.
        bus.out_ready   = 1'b1;
        first_valid_cyc = -1;
        first_acc_cyc   = -1;
        pulse_start();
        @(negedge tb_clk);
        chk("busy_in_run", busy, 1);
        step();
        for (int i = 0; i < 8; i++) send(64, 64, 10);
        wait_done("full");
        chk("first_valid_latency", first_valid_cyc - first_acc_cyc, 3);

        // Backpressure: input held valid, output stalled.
        bus.out_ready = 1'b0;
        pulse_start();
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_gy    = '0;
        for (int i = 0; i < 40; i++) begin
            if (n < 8) bus.in_gx = 10'(gx_bp[n]);
            @(negedge tb_clk);
            if (bus.in_ready === 1'b1) begin
                if (n < 8) push_exp(exp_bp[n]);
                n++;
            end
            step();
        end
        chk("bp_accepts", n, 8);
        @(negedge tb_clk);
        chk("bp_in_ready_stalled", bus.in_ready, 0);
        chk("bp_out_valid_held", bus.out_valid, 1);
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_done("bp");

        // Value ordering with out_ready toggling each cycle.
        tog = 1'b1;
        pulse_start();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) send(gv_ord[i], gv_ord[i], exp_ord[i]);
        end
        wait_done("order");
        tog = 1'b0;
        bus.out_ready = 1'b1;
        step();

        // start pulsed mid-frame must not restart the frame.
        pulse_start();
        send(64, 64, 10);
        send(64, 64, 10);
        pulse_start();
        @(negedge tb_clk);
        chk("busy_after_spurious_start", busy, 1);
        step();
        for (int i = 0; i < 6; i++) send(64, 64, 10);
        wait_done("start_ignored");

        // Reset after 3 accepts with pixels buffered and in flight.
        bus.out_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 3; i++) send(64, 64, 10);
        step();
        rst = 1'b1;
        sb.delete();
        m_row = 0;
        m_col = 0;
        step();
        @(negedge tb_clk);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_out_valid", bus.out_valid, 0);
        step();
        @(negedge tb_clk);
        chk_reset("rst_mid");
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        pulse_start();
        for (int i = 0; i < 8; i++) send(64, 64, 10);
        wait_done("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
